vga_mode_ctrl: RTL

//  Parametrised VGA scan-out engine with CPU register file, 1bpp/2bpp modes, 4-entry palette,

---
 rtl/vga_mode_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_mode_ctrl.sv
// VGA scan-out engine: CPU register file, 1bpp/2bpp palette lookup, programmable base/stride,
// line doubling and vblank interrupt, all clocked by cpu_clk and advanced on pix_ce ticks.
module vga_mode_ctrl #(
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SP    = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SP    = 2,
    parameter int V_BP    = 33,
    parameter int PIX_REP = 2,
    parameter int ADDR_W  = 16
) (
    input  logic              cpu_clk,
    input  logic              rst,
    input  logic              pix_ce,
    input  logic [2:0]        cpu_addr,
    input  logic [7:0]        cpu_dbw,
    input  logic              cpu_we,
    output logic [7:0]        cpu_dbr,
    output logic              irq,
    output logic              hsync,
    output logic              vsync,
    output logic [3:0]        rgbi,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data
);

    localparam int H_TOT = H_VIS + H_FP + H_SP + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SP + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int RW    = $clog2(PIX_REP + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_L  = HW'(H_VIS);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_VIS + H_FP + H_SP);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_L  = VW'(V_VIS);
    localparam logic [VW-1:0] V_IRQ    = VW'(V_VIS - 1);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_VIS + V_FP + V_SP);
    localparam logic [RW-1:0] REP_LAST = RW'(PIX_REP - 1);

    logic              mode_bpp_r, mode_dbl_r, mode_ie_r;
    logic [3:0]        pal0_r, pal1_r, pal2_r, pal3_r;
    logic [ADDR_W-1:0] base_r;
    logic [7:0]        stride_r;
    logic              irq_pend_r;

    logic              bpp_sh_r, dbl_sh_r;
    logic [7:0]        stride_sh_r;
    logic [HW-1:0]     h_r;
    logic [VW-1:0]     v_r;
    logic [RW-1:0]     rep_r;
    logic [2:0]        pix_r;
    logic [7:0]        shift_r;
    logic [ADDR_W-1:0] line_ptr_r;
    logic              odd_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [3:0]        rgbi_r;
    logic              hsync_r, vsync_r;

    logic [15:0]       base16_s;
    logic              h_last_s, v_last_s, h_vis_s, visible_s, vblank_s;
    logic              rep_last_s, pix_last_s, byte_first_s, line_adv_s;
    logic              irq_set_s, irq_clr_s;
    logic [ADDR_W-1:0] nxt_ptr_s;
    logic [1:0]        idx_s;
    logic [3:0]        colour_s;

    assign base16_s     = 16'(base_r);
    assign h_last_s     = (h_r == H_LAST);
    assign v_last_s     = (v_r == V_LAST);
    assign h_vis_s      = (h_r < H_VIS_L);
    assign visible_s    = h_vis_s && (v_r < V_VIS_L);
    assign vblank_s     = (v_r >= V_VIS_L);
    assign rep_last_s   = (rep_r == REP_LAST);
    assign pix_last_s   = (pix_r == (bpp_sh_r ? 3'd3 : 3'd7));
    assign byte_first_s = (rep_r == RW'(0)) && (pix_r == 3'd0);
    // With line doubling the pointer only advances after the second copy of a line.
    assign line_adv_s   = (v_r < V_VIS_L) && (!dbl_sh_r || odd_r);
    assign nxt_ptr_s    = v_last_s   ? base_r :
                          line_adv_s ? line_ptr_r + ADDR_W'(stride_sh_r) : line_ptr_r;
    assign irq_set_s    = pix_ce && h_last_s && (v_r == V_IRQ);
    assign irq_clr_s    = cpu_we && (cpu_addr == 3'd6) && cpu_dbw[1];

    assign irq      = irq_pend_r & mode_ie_r;
    assign hsync    = hsync_r;
    assign vsync    = vsync_r;
    assign rgbi     = rgbi_r;
    assign mem_addr = mem_addr_r;

    // Palette lookup of the pixel currently at the bottom of the shift register.
    always_comb begin
        idx_s    = bpp_sh_r ? shift_r[1:0] : {1'b0, shift_r[0]};
        colour_s = pal0_r;
        case (idx_s)
            2'd0:    colour_s = pal0_r;
            2'd1:    colour_s = pal1_r;
            2'd2:    colour_s = pal2_r;
            2'd3:    colour_s = pal3_r;
            default: colour_s = pal0_r;
        endcase
    end

    // CPU read mux; unlisted bits and the reserved register read as zero.
    always_comb begin
        cpu_dbr = 8'h00;
        case (cpu_addr)
            3'd0:    cpu_dbr = {mode_ie_r, 5'b00000, mode_dbl_r, mode_bpp_r};
            3'd1:    cpu_dbr = {pal1_r, pal0_r};
            3'd2:    cpu_dbr = {pal3_r, pal2_r};
            3'd3:    cpu_dbr = base16_s[15:8];
            4'd4:    cpu_dbr = base16_s[7:0];
            3'd5:    cpu_dbr = stride_r;
            3'd6:    cpu_dbr = {6'b000000, irq_pend_r, vblank_s};
            default: cpu_dbr = 8'h00;
        endcase
    end

    // CPU register writes, independent of pix_ce.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            mode_bpp_r <= 1'b0;
            mode_dbl_r <= 1'b0;
            mode_ie_r  <= 1'b0;
            pal0_r     <= 4'h1;
            pal1_r     <= 4'hF;
            pal2_r     <= 4'h4;
            pal3_r     <= 4'hE;
            base_r     <= '0;
            stride_r   <= 8'd40;
        end else if (cpu_we) begin
            case (cpu_addr)
                3'd0: begin
                    mode_bpp_r <= cpu_dbw[0];
                    mode_dbl_r <= cpu_dbw[1];
                    mode_ie_r  <= cpu_dbw[7];
                end
                3'd1: begin
                    pal0_r <= cpu_dbw[3:0];
                    pal1_r <= cpu_dbw[7:4];
                end
                3'd2: begin
                    pal2_r <= cpu_dbw[3:0];
                    pal3_r <= cpu_dbw[7:4];
                end
                3'd3:    base_r   <= ADDR_W'({cpu_dbw, base16_s[7:0]});
                3'd4:    base_r   <= ADDR_W'({base16_s[15:8], cpu_dbw});
                3'd5:    stride_r <= cpu_dbw;
                default: ;
            endcase
        end
    end

    // Interrupt pending flag; a set on the same cycle as a clear wins.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            irq_pend_r <= 1'b0;
        end else if (irq_set_s) begin
            irq_pend_r <= 1'b1;
        end else if (irq_clr_s) begin
            irq_pend_r <= 1'b0;
        end
    end

    // Raster counters and per-pixel shift register.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            h_r     <= '0;
            v_r     <= '0;
            rep_r   <= '0;
            pix_r   <= 3'd0;
            shift_r <= 8'h00;
        end else if (pix_ce) begin
            h_r <= h_last_s ? '0 : h_r + HW'(1);
            if (h_last_s) begin
                v_r     <= v_last_s ? '0 : v_r + VW'(1);
                rep_r   <= '0;
                pix_r   <= 3'd0;
                shift_r <= mem_data;
            end else if (h_vis_s) begin
                if (rep_last_s) begin
                    rep_r <= '0;
                    if (pix_last_s) begin
                        pix_r   <= 3'd0;
                        shift_r <= mem_data;
                    end else begin
                        pix_r   <= pix_r + 3'd1;
                        shift_r <= bpp_sh_r ? {2'b00, shift_r[7:2]} : {1'b0, shift_r[7:1]};
                    end
                end else begin
                    rep_r <= rep_r + RW'(1);
                end
            end
        end
    end

    // Line pointer, doubling phase and per-frame shadows taken at the frame wrap.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            line_ptr_r  <= '0;
            odd_r       <= 1'b0;
            bpp_sh_r    <= 1'b0;
            dbl_sh_r    <= 1'b0;
            stride_sh_r <= 8'd40;
        end else if (pix_ce && h_last_s) begin
            line_ptr_r <= nxt_ptr_s;
            if (v_last_s) begin
                odd_r       <= 1'b0;
                bpp_sh_r    <= mode_bpp_r;
                dbl_sh_r    <= mode_dbl_r;
                stride_sh_r <= stride_r;
            end else if (v_r < V_VIS_L) begin
                odd_r <= dbl_sh_r ? ~odd_r : 1'b0;
            end
        end
    end

    // Next line's first byte is addressed as soon as the visible part ends.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            mem_addr_r <= '0;
        end else if (pix_ce) begin
            if (h_r == H_VIS_L) begin
                mem_addr_r <= nxt_ptr_s;
            end else if (h_vis_s && byte_first_s) begin
                mem_addr_r <= mem_addr_r + ADDR_W'(1);
            end
        end
    end

    // Output stage: colour and syncs registered together for alignment.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            rgbi_r  <= 4'h0;
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
        end else if (pix_ce) begin
            rgbi_r  <= visible_s ? colour_s : 4'h0;
            hsync_r <= !((h_r >= H_SYNC_S) && (h_r < H_SYNC_E));
            vsync_r <= !((v_r >= V_SYNC_S) && (v_r < V_SYNC_E));
        end
    end

endmodule
